dmem_rmw_ctrl: RTL
==================

Name: dmem_rmw_ctrl

Overview:
Sequencing controller between the MEM-stage pipeline register and the synchronous-read data memory.
- Per load/store request: reads the aligned word from memory and routes it through the sub-word load/store unit.
- Loads: returns the extracted/extended value.
- Sub-word and word stores: writes back the merged word, as a read-modify-write.
- Holds the pipeline (busy) while an access is in flight.

Parameters:
- AW, 32, byte address width.
- DW, 32, data word width. Fixed at 32; 4 bytes per word.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  MEM stage presents an access.
- req_ready  out  1  controller accepts a request this cycle.
- req_addr  in  AW  byte address.
- req_access  in  4  access code, dmem_type.vh encoding (LD_*_D / ST_*_D).
- req_wdata  in  DW  store data, right-aligned.
- busy  out  1  pipeline stall; high whenever state != IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DW  load result.
- resp_err  out  1  misaligned access flagged.
- mem_addr  out  AW  word address, {addr_q[AW-1:2],2'b00}.
- mem_re  out  1  read strobe; data valid on mem_rdata the next cycle.
- mem_rdata  in  DW  memory read data.
- mem_we  out  1  write strobe; committed at rising edge.
- mem_wdata  out  DW  write data.
- slu_addr  out  AW  =addr_q.
- slu_access  out  4  =access_q.
- slu_rd_in  out  DW  =word_q.
- slu_wd_in  out  DW  =wdata_q.
- slu_rd_out  in  DW  extracted load value from SLU.
- slu_wd_out  in  DW  merged store word from SLU.

Behaviour:
- States:
  - IDLE: req_ready=1.
  - RD: mem_re=1.
  - WAIT: word_q<=mem_rdata at end of cycle.
  - WR: mem_we=1, mem_wdata=slu_wd_out.
  - RESP: resp_valid=1.
- Accept in IDLE on req_valid. Latch addr_q, access_q, wdata_q. Classify request:
  - Load: LD_B_D, LD_H_D, LD_W_D, LD_BU_D, LD_HU_D.
  - Store: ST_B_D, ST_H_D, ST_W_D.
  - Other codes: NOP.
- Misaligned accesses: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - IDLE->RESP directly; no mem_re, no mem_we.
  - resp_err=1, resp_rdata=0.
- NOP: IDLE->RESP. resp_err=0, resp_rdata=0.
- Load path: IDLE->RD->WAIT->RESP. resp_rdata=slu_rd_out (computed from word_q).
- Store path: IDLE->RD->WAIT->WR->RESP. resp_rdata=0.
- Latency, accept cycle = 0:
  - Load: resp_valid in cycle 3.
  - Store: resp_valid in cycle 4.
  - Misaligned/NOP: resp_valid in cycle 1.
- RESP always returns to IDLE. Next accept is no earlier than the cycle after RESP; req_ready=0 in every non-IDLE state.
- Request fields may change after acceptance. The controller uses only the latched copies.
- mem_addr holds {addr_q[31:2],2'b00} in RD/WR and is 0 elsewhere. mem_re/mem_we are never both high.
- Reset:
  - rst forces IDLE at the next edge.
  - addr_q/access_q/wdata_q/word_q reset to 0.
  - Outputs then: req_ready=1, busy=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_re=0, mem_we=0, mem_wdata=0.
  - mem_we is gated by ~rst, so a write pending in WR is not committed when rst is high that cycle.
  - A read issued in RD during rst is discarded.
- resp_rdata/resp_err are 0 in every cycle where resp_valid=0.

Optional Feature:
- Macro: DMEM_FAST_STW_EN.
- Defined: an aligned ST_W_D skips RD/WAIT, taking IDLE->WR->RESP. mem_wdata=wdata_q and resp_valid lands in cycle 2. Other stores are unchanged.
- Undefined: ST_W_D takes the full read-modify-write path, with resp_valid in cycle 4.

Test Plan:
- Memory[0x100]=0x11223344; LD_B_D at 0x103 -> mem_re cycle 1 with mem_addr=0x100; resp_valid cycle 3, resp_rdata=0x00000011, resp_err=0.
- Same memory; ST_B_D at 0x101, wdata=0x000000AB -> mem_we cycle 3, mem_addr=0x100, mem_wdata=0x1122AB44; resp_valid cycle 4; memory reads back 0x1122AB44.
- LD_H_D at 0x101 -> no mem_re/mem_we; resp_valid cycle 1, resp_err=1, resp_rdata=0; busy high cycle 1 only.
- ST_H_D at 0x102, wdata=0xBEEF, rst high during WR cycle -> mem_we=0 that cycle; next cycle IDLE, req_ready=1, all outputs 0; memory still 0x11223344.
- ST_W_D at 0x100, wdata=0xDEADBEEF -> with DMEM_FAST_STW_EN: no mem_re, mem_we cycle 1, resp_valid cycle 2; without the macro: mem_re cycle 1, mem_we cycle 3, resp_valid cycle 4.
- req_valid held high with LD_W_D 0x100 then LD_BU_D 0x102 -> first resp_rdata=0x11223344 (cycle 3); second accepted cycle 4, resp_rdata=0x00000022 (cycle 7).

Source files
------------

// File: rtl/dmem_rmw_ctrl.sv
// Data-memory sequencer: load, read-modify-write store and misaligned/NOP short-cut paths.
// Optional DMEM_FAST_STW_EN: aligned ST_W_D writes directly without the read phase.
module dmem_rmw_ctrl #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [3:0]    req_access,
   input  logic [DW-1:0] req_wdata,
   output logic          busy,
   output logic          resp_valid,
   output logic [DW-1:0] resp_rdata,
   output logic          resp_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_re,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   output logic [AW-1:0] slu_addr,
   output logic [3:0]    slu_access,
   output logic [DW-1:0] slu_rd_in,
   output logic [DW-1:0] slu_wd_in,
   input  logic [DW-1:0] slu_rd_out,
   input  logic [DW-1:0] slu_wd_out
);

   // Access codes as defined in dmem_type.vh; every other code is a NOP.
   localparam logic [3:0] LD_B_D  = 4'd1;
   localparam logic [3:0] LD_H_D  = 4'd2;
   localparam logic [3:0] LD_W_D  = 4'd3;
   localparam logic [3:0] LD_BU_D = 4'd4;
   localparam logic [3:0] LD_HU_D = 4'd5;
   localparam logic [3:0] ST_B_D  = 4'd9;
   localparam logic [3:0] ST_H_D  = 4'd10;
   localparam logic [3:0] ST_W_D  = 4'd11;

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

   state_t        state;
   logic [AW-1:0] addr_q;
   logic [3:0]    access_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] word_q;
   logic [DW-1:0] wr_data;

   function automatic logic is_ld(input logic [3:0] a);
      return a inside {LD_B_D, LD_H_D, LD_W_D, LD_BU_D, LD_HU_D};
   endfunction

   function automatic logic is_st(input logic [3:0] a);
      return a inside {ST_B_D, ST_H_D, ST_W_D};
   endfunction

   function automatic logic is_mis(input logic [3:0] a, input logic [1:0] lo);
      return ((a inside {LD_H_D, LD_HU_D, ST_H_D}) && lo[0]) ||
             ((a inside {LD_W_D, ST_W_D}) && (lo != 2'b00));
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         addr_q   <= '0;
         access_q <= '0;
         wdata_q  <= '0;
         word_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q   <= req_addr;
                  access_q <= req_access;
                  wdata_q  <= req_wdata;
                  if (is_mis(req_access, req_addr[1:0]) ||
                      !(is_ld(req_access) || is_st(req_access)))
                     state <= RESP;
`ifdef DMEM_FAST_STW_EN
                  else if (req_access == ST_W_D)
                     state <= WR;
`endif
                  else
                     state <= RD;
               end
            end
            RD:   state <= WAIT;
            WAIT: begin
               word_q <= mem_rdata;
               state  <= is_st(access_q) ? WR : RESP;
            end
            WR:      state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_FAST_STW_EN
   // Only the fast path reaches WR with ST_W_D, and it has no merged word.
   assign wr_data = (access_q == ST_W_D) ? wdata_q : slu_wd_out;
`else
   assign wr_data = slu_wd_out;
`endif

   assign req_ready  = (state == IDLE);
   assign busy       = (state != IDLE);
   assign mem_re     = (state == RD);
   assign mem_we     = (state == WR) && !rst;
   assign mem_addr   = ((state == RD) || (state == WR)) ? {addr_q[AW-1:2], 2'b00} : '0;
   assign mem_wdata  = (state == WR) ? wr_data : '0;
   assign resp_valid = (state == RESP);
   assign resp_err   = (state == RESP) && is_mis(access_q, addr_q[1:0]);
   assign resp_rdata = ((state == RESP) && is_ld(access_q) && !is_mis(access_q, addr_q[1:0]))
                       ? slu_rd_out : '0;

   assign slu_addr   = addr_q;
   assign slu_access = access_q;
   assign slu_rd_in  = word_q;
   assign slu_wd_in  = wdata_q;

endmodule
